// File: rtl/idx_encode_unit_if.sv
// Request/result bundle for idx_encode_unit: capture strobe plus both input vectors, registered results.
// Signals only, no latency of its own; no backpressure (results follow every valid_i unconditionally).
// onehot_err_o exists only when IDX_ENCODE_ONEHOT_CHECK_EN is defined.
interface idx_encode_unit_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             valid_i;
    logic [WIDTH-1:0] vec_i;
    logic [WIDTH-1:0] onehot_i;
    logic             valid_o;
    logic [CNT_W-1:0] cnt_o;
    logic             empty_o;
    logic [CNT_W-1:0] bin_o;
`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
    logic             onehot_err_o;
`endif

    modport master (
        output valid_i, vec_i, onehot_i,
        input  valid_o, cnt_o, empty_o, bin_o
`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
        , input onehot_err_o
`endif
    );

    modport slave (
        input  valid_i, vec_i, onehot_i,
        output valid_o, cnt_o, empty_o, bin_o
`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
        , output onehot_err_o
`endif
    );
endinterface

// File: rtl/idx_encode_unit.sv
// Priority-encodes vec_i (trailing/leading zero count + empty) and converts onehot_i to binary; optional multi-hot check under IDX_ENCODE_ONEHOT_CHECK_EN.
// Latency 1 cycle: results registered on valid_i, valid_o follows valid_i every clock.
// No backpressure: every valid_i is captured; data outputs hold while valid_i is low.
module idx_encode_unit #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    idx_encode_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PAD_W = 1 << CNT_W;

    logic [PAD_W-1:0] leaf;
    logic [PAD_W-1:0] node_vld [CNT_W+1];
    logic [CNT_W-1:0] node_idx [CNT_W+1][PAD_W];
    logic             empty_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] bin_nxt;

    // Leading-zero mode mirrors the vector so one lowest-set-bit tree serves both modes.
    // Padding leaves stay zero, so indices >= WIDTH can never win.
    always_comb begin
        leaf = '0;
        for (int i = 0; i < WIDTH; i++) begin
            leaf[i] = (MODE == 1) ? bus.vec_i[WIDTH-1-i] : bus.vec_i[i];
        end
    end

    always_comb begin
        for (int l = 0; l <= CNT_W; l++) begin
            node_vld[l] = '0;
            for (int k = 0; k < PAD_W; k++) begin
                node_idx[l][k] = '0;
            end
        end
        node_vld[0] = leaf;
        for (int k = 0; k < PAD_W; k++) begin
            node_idx[0][k] = CNT_W'(k);
        end
        // Each level merges pairs, the lower-indexed child taking priority.
        for (int l = 0; l < CNT_W; l++) begin
            for (int k = 0; k < (PAD_W >> (l + 1)); k++) begin
                node_vld[l+1][k] = node_vld[l][2*k] | node_vld[l][2*k+1];
                node_idx[l+1][k] = node_vld[l][2*k] ? node_idx[l][2*k] : node_idx[l][2*k+1];
            end
        end
    end

    assign empty_nxt = ~node_vld[CNT_W][0];
    assign cnt_nxt   = empty_nxt ? '0 : node_idx[CNT_W][0];

    // Each binary bit is the OR of all inputs whose index has that bit set; multi-hot ORs indices.
    always_comb begin
        bin_nxt = '0;
        for (int b = 0; b < CNT_W; b++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> b) & 1) != 0) begin
                    bin_nxt[b] = bin_nxt[b] | bus.onehot_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.valid_o <= 1'b0;
            bus.cnt_o   <= '0;
            bus.empty_o <= 1'b1;
            bus.bin_o   <= '0;
        end else begin
            bus.valid_o <= bus.valid_i;
            if (bus.valid_i) begin
                bus.cnt_o   <= cnt_nxt;
                bus.empty_o <= empty_nxt;
                bus.bin_o   <= bin_nxt;
            end
        end
    end

`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
    logic err_nxt;

    // Clearing the lowest set bit leaves something only if more than one bit was set.
    assign err_nxt = |(bus.onehot_i & (bus.onehot_i - WIDTH'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.onehot_err_o <= 1'b0;
        end else if (bus.valid_i) begin
            bus.onehot_err_o <= err_nxt;
        end
    end

`ifndef SYNTHESIS
    onehot_err_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.valid_o && bus.onehot_err_o))
        else $warning("idx_encode_unit: multi-hot match vector captured");
`endif
`endif

endmodule

// File: tb/tb_idx_encode_unit.sv
// Directed bench for idx_encode_unit: one instance per MODE driven with identical stimulus.
module tb_idx_encode_unit;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    idx_encode_unit_if #(.WIDTH(8)) if0 ();
    idx_encode_unit_if #(.WIDTH(8)) if1 ();

    idx_encode_unit #(.WIDTH(8), .MODE(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
    idx_encode_unit #(.WIDTH(8), .MODE(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after a rising edge; results are observed 1 unit after the next one.
    task automatic drive(input logic v, input logic [7:0] vec, input logic [7:0] oh);
        if0.valid_i = v; if0.vec_i = vec; if0.onehot_i = oh;
        if1.valid_i = v; if1.vec_i = vec; if1.onehot_i = oh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.valid_i = 1'b1; if0.vec_i = 8'h28; if0.onehot_i = 8'h40;
        if1.valid_i = 1'b1; if1.vec_i = 8'h28; if1.onehot_i = 8'h40;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid0: got %b want 0", if0.valid_o); end
        n_cmp++; if (if0.cnt_o !== 3'd0)   begin n_bad++; $display("FAIL reset_cnt0: got %0d want 0", if0.cnt_o); end
        n_cmp++; if (if0.empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty0: got %b want 1", if0.empty_o); end
        n_cmp++; if (if0.bin_o !== 3'd0)   begin n_bad++; $display("FAIL reset_bin0: got %0d want 0", if0.bin_o); end
        n_cmp++; if (if1.cnt_o !== 3'd0)   begin n_bad++; $display("FAIL reset_cnt1: got %0d want 0", if1.cnt_o); end
        n_cmp++; if (if1.empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty1: got %b want 1", if1.empty_o); end
`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
        n_cmp++; if (if0.onehot_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", if0.onehot_err_o); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        if0.valid_i = 1'b0; if1.valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_count();
        logic [7:0] vecs [6] = '{8'h28, 8'h80, 8'h01, 8'hFF, 8'h0C, 8'h40};
        logic [2:0] tz   [6] = '{3'd3,  3'd7,  3'd0,  3'd0,  3'd2,  3'd6};
        logic [2:0] lz   [6] = '{3'd2,  3'd0,  3'd7,  3'd0,  3'd4,  3'd1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i], 8'h00);
            n_cmp++; if (if0.valid_o !== 1'b1) begin n_bad++; $display("FAIL cnt_valid[%0d]: got %b want 1", i, if0.valid_o); end
            n_cmp++; if (if0.cnt_o !== tz[i])  begin n_bad++; $display("FAIL tzc[%0d]: vec %h got %0d want %0d", i, vecs[i], if0.cnt_o, tz[i]); end
            n_cmp++; if (if1.cnt_o !== lz[i])  begin n_bad++; $display("FAIL lzc[%0d]: vec %h got %0d want %0d", i, vecs[i], if1.cnt_o, lz[i]); end
            n_cmp++; if (if0.empty_o !== 1'b0) begin n_bad++; $display("FAIL cnt_empty[%0d]: got %b want 0", i, if0.empty_o); end
        end
    endtask

    task automatic test_empty();
        drive(1'b1, 8'h00, 8'h00);
        n_cmp++; if (if0.cnt_o !== 3'd0)   begin n_bad++; $display("FAIL empty_cnt0: got %0d want 0", if0.cnt_o); end
        n_cmp++; if (if1.cnt_o !== 3'd0)   begin n_bad++; $display("FAIL empty_cnt1: got %0d want 0", if1.cnt_o); end
        n_cmp++; if (if0.empty_o !== 1'b1) begin n_bad++; $display("FAIL empty_flag0: got %b want 1", if0.empty_o); end
        n_cmp++; if (if1.empty_o !== 1'b1) begin n_bad++; $display("FAIL empty_flag1: got %b want 1", if1.empty_o); end
    endtask

    task automatic test_onehot();
        logic [7:0] ohs [5] = '{8'h40, 8'h01, 8'h80, 8'h00, 8'h08};
        logic [2:0] bin [5] = '{3'd6,  3'd0,  3'd7,  3'd0,  3'd3};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h01, ohs[i]);
            n_cmp++; if (if0.bin_o !== bin[i]) begin n_bad++; $display("FAIL onehot_bin[%0d]: oh %h got %0d want %0d", i, ohs[i], if0.bin_o, bin[i]); end
`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
            n_cmp++; if (if0.onehot_err_o !== 1'b0) begin n_bad++; $display("FAIL onehot_err[%0d]: got %b want 0", i, if0.onehot_err_o); end
`endif
        end
    endtask

    task automatic test_multihot();
        logic [7:0] ohs [5] = '{8'h06, 8'h81, 8'h14, 8'hFF, 8'h30};
        logic [2:0] bin [5] = '{3'd3,  3'd7,  3'd6,  3'd7,  3'd5};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h01, ohs[i]);
            n_cmp++; if (if1.bin_o !== bin[i]) begin n_bad++; $display("FAIL multihot_bin[%0d]: oh %h got %0d want %0d", i, ohs[i], if1.bin_o, bin[i]); end
`ifdef IDX_ENCODE_ONEHOT_CHECK_EN
            n_cmp++; if (if1.onehot_err_o !== 1'b1) begin n_bad++; $display("FAIL multihot_err[%0d]: got %b want 1", i, if1.onehot_err_o); end
`endif
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 8'h28, 8'h40);
        drive(1'b0, 8'h01, 8'h02);
        n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL hold_valid: got %b want 0", if0.valid_o); end
        n_cmp++; if (if0.cnt_o !== 3'd3)   begin n_bad++; $display("FAIL hold_cnt0: got %0d want 3", if0.cnt_o); end
        n_cmp++; if (if1.cnt_o !== 3'd2)   begin n_bad++; $display("FAIL hold_cnt1: got %0d want 2", if1.cnt_o); end
        n_cmp++; if (if0.bin_o !== 3'd6)   begin n_bad++; $display("FAIL hold_bin: got %0d want 6", if0.bin_o); end
        drive(1'b0, 8'h00, 8'h00);
        n_cmp++; if (if0.empty_o !== 1'b0) begin n_bad++; $display("FAIL hold_empty: got %b want 0", if0.empty_o); end
        n_cmp++; if (if1.cnt_o !== 3'd2)   begin n_bad++; $display("FAIL hold_cnt1b: got %0d want 2", if1.cnt_o); end
        drive(1'b1, 8'h80, 8'h10);
        n_cmp++; if (if0.cnt_o !== 3'd7)   begin n_bad++; $display("FAIL hold_resume_cnt: got %0d want 7", if0.cnt_o); end
        n_cmp++; if (if0.bin_o !== 3'd4)   begin n_bad++; $display("FAIL hold_resume_bin: got %0d want 4", if0.bin_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vecs [4] = '{8'h01, 8'h80, 8'h00, 8'h10};
        logic [7:0] ohs  [4] = '{8'h80, 8'h01, 8'h20, 8'h00};
        logic [2:0] tz   [4] = '{3'd0,  3'd7,  3'd0,  3'd4};
        logic [2:0] lz   [4] = '{3'd7,  3'd0,  3'd0,  3'd3};
        logic [2:0] bin  [4] = '{3'd7,  3'd0,  3'd5,  3'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vecs[i], ohs[i]);
            n_cmp++; if (if0.cnt_o !== tz[i])  begin n_bad++; $display("FAIL b2b_tzc[%0d]: got %0d want %0d", i, if0.cnt_o, tz[i]); end
            n_cmp++; if (if1.cnt_o !== lz[i])  begin n_bad++; $display("FAIL b2b_lzc[%0d]: got %0d want %0d", i, if1.cnt_o, lz[i]); end
            n_cmp++; if (if0.bin_o !== bin[i]) begin n_bad++; $display("FAIL b2b_bin[%0d]: got %0d want %0d", i, if0.bin_o, bin[i]); end
            n_cmp++; if (if0.empty_o !== (vecs[i] == 8'h00)) begin n_bad++; $display("FAIL b2b_empty[%0d]: got %b want %b", i, if0.empty_o, vecs[i] == 8'h00); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h28, 8'h40);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", if0.valid_o); end
        n_cmp++; if (if0.cnt_o !== 3'd0)   begin n_bad++; $display("FAIL arst_cnt0: got %0d want 0", if0.cnt_o); end
        n_cmp++; if (if1.cnt_o !== 3'd0)   begin n_bad++; $display("FAIL arst_cnt1: got %0d want 0", if1.cnt_o); end
        n_cmp++; if (if0.empty_o !== 1'b1) begin n_bad++; $display("FAIL arst_empty: got %b want 1", if0.empty_o); end
        n_cmp++; if (if0.bin_o !== 3'd0)   begin n_bad++; $display("FAIL arst_bin: got %0d want 0", if0.bin_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h04, 8'h04);
        n_cmp++; if (if0.cnt_o !== 3'd2)   begin n_bad++; $display("FAIL arst_after_cnt: got %0d want 2", if0.cnt_o); end
        n_cmp++; if (if1.cnt_o !== 3'd5)   begin n_bad++; $display("FAIL arst_after_lzc: got %0d want 5", if1.cnt_o); end
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_empty();
        test_onehot();
        test_multihot();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
